// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle logic/arith ops, iterative shifts and shift-add multiply
//
// Purpose: accepts an operation when Start=1 and the unit is idle, produces a
// registered result plus status flags, and pulses Done for one cycle after the
// result lands. Shifts by k>=1 walk one bit per cycle; MUL runs W shift-add
// steps. Optional feature macro: ALU_SEQ_MUL_EN (enables the iterative MUL;
// without it MUL returns 0 in a single cycle and no multiplier datapath exists).
//
// Ports:
//   Clk              in   clock, rising edge
//   Reset            in   synchronous, active-high
//   Start            in   request, accepted when Busy=0
//   InputA, InputB   in   W-bit operands, sampled at accept
//   OP               in   Ops-bit opcode, sampled at accept
//   Out              out  W-bit registered result
//   Busy             out  high while a multi-cycle op executes
//   Done             out  one-cycle completion pulse
//   Zero, Parity,
//   Odd, Carry       out  registered status flags
module alu_seq #(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [W-1:0]   InputA,
  input  logic [W-1:0]   InputB,
  input  logic [Ops-1:0] OP,
  output logic [W-1:0]   Out,
  output logic           Busy,
  output logic           Done,
  output logic           Zero,
  output logic           Parity,
  output logic           Odd,
  output logic           Carry
);

  localparam int KW = $clog2(W);
  // One extra bit so the counter holds W (MUL) as well as any k.
  localparam int CW = KW + 1;

  localparam logic [Ops-1:0] OP_ADD = Ops'(0);
  localparam logic [Ops-1:0] OP_SUB = Ops'(1);
  localparam logic [Ops-1:0] OP_AND = Ops'(2);
  localparam logic [Ops-1:0] OP_OR  = Ops'(3);
  localparam logic [Ops-1:0] OP_XOR = Ops'(4);
  localparam logic [Ops-1:0] OP_LSH = Ops'(5);
  localparam logic [Ops-1:0] OP_RSH = Ops'(6);
  localparam logic [Ops-1:0] OP_NEG = Ops'(7);
  localparam logic [Ops-1:0] OP_GEQ = Ops'(8);
  localparam logic [Ops-1:0] OP_EQ  = Ops'(9);
  localparam logic [Ops-1:0] OP_NEQ = Ops'(10);
  localparam logic [Ops-1:0] OP_MUL = Ops'(11);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t        r_state;
  logic [W-1:0]  r_out;
  logic          r_done, r_zero, r_parity, r_odd, r_carry;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_lo;     // shift operand, or multiplier / low product half
  logic          r_lsh;

  logic [KW-1:0] w_k;
  logic          w_hi_set, w_is_shift, w_is_mul, w_multi;
  logic [W:0]    w_add, w_sub;
  logic [W-1:0]  w_sc_val, w_it_val, w_fin_val;
  logic          w_sc_c, w_it_c, w_fin_c;

  assign w_k        = InputB[KW-1:0];
  assign w_hi_set   = |InputB[W-1:KW];
  assign w_is_shift = (OP == OP_LSH) || (OP == OP_RSH);
  assign w_add      = {1'b0, InputA} + {1'b0, InputB};
  assign w_sub      = {1'b0, InputA} - {1'b0, InputB};

`ifdef ALU_SEQ_MUL_EN
  logic          r_mul;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_mcand;
  logic [W:0]    w_mul_sum;

  assign w_is_mul  = (OP == OP_MUL);
  // Add the multiplicand into the high half when the current multiplier bit
  // is set; the {sum, lo} pair then shifts right one place.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_it_val  = r_mul ? {w_mul_sum[0], r_lo[W-1:1]}
                           : (r_lsh ? (r_lo << 1) : (r_lo >> 1));
  assign w_it_c    = r_mul ? (|w_mul_sum[W:1])
                           : (r_lsh ? r_lo[W-1] : r_lo[0]);
`else
  assign w_is_mul  = 1'b0;
  assign w_it_val  = r_lsh ? (r_lo << 1) : (r_lo >> 1);
  assign w_it_c    = r_lsh ? r_lo[W-1] : r_lo[0];
`endif

  assign w_multi = (w_is_shift && !w_hi_set && (w_k != '0)) || w_is_mul;

  always_comb begin
    w_sc_val = '0;
    w_sc_c   = 1'b0;
    case (OP)
      OP_ADD: begin w_sc_val = w_add[W-1:0]; w_sc_c = w_add[W]; end
      OP_SUB: begin w_sc_val = w_sub[W-1:0]; w_sc_c = (InputA < InputB); end
      OP_AND: w_sc_val = InputA & InputB;
      OP_OR:  w_sc_val = InputA | InputB;
      OP_XOR: w_sc_val = InputA ^ InputB;
      // Only the k=0 and out-of-range cases finish here.
      OP_LSH, OP_RSH: w_sc_val = w_hi_set ? '0 : InputA;
      OP_NEG: w_sc_val = '0 - InputA;
      OP_GEQ: w_sc_val = W'(InputA >= InputB);
      OP_EQ:  w_sc_val = W'(InputA == InputB);
      OP_NEQ: w_sc_val = W'(InputA != InputB);
      OP_MUL: w_sc_val = '0;
      default: w_sc_val = '0;
    endcase
  end

  assign w_fin_val = (r_state == S_EXEC) ? w_it_val : w_sc_val;
  assign w_fin_c   = (r_state == S_EXEC) ? w_it_c   : w_sc_c;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_out    <= '0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
      r_parity <= 1'b0;
      r_odd    <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_lo     <= '0;
      r_lsh    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_mul    <= 1'b0;
      r_hi     <= '0;
      r_mcand  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (w_multi) begin
              r_state <= S_EXEC;
              r_lsh   <= (OP == OP_LSH);
              r_lo    <= InputA;
              r_cnt   <= {1'b0, w_k};
`ifdef ALU_SEQ_MUL_EN
              r_mul   <= w_is_mul;
              r_hi    <= '0;
              r_mcand <= InputA;
              if (w_is_mul) begin
                r_lo  <= InputB;
                r_cnt <= CW'(W);
              end
`endif
            end else begin
              r_out    <= w_fin_val;
              r_zero   <= (w_fin_val == '0);
              r_parity <= ^w_fin_val;
              r_odd    <= w_fin_val[0];
              r_carry  <= w_fin_c;
              r_done   <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - CW'(1);
          r_lo  <= w_it_val;
`ifdef ALU_SEQ_MUL_EN
          r_hi  <= w_mul_sum[W:1];
`endif
          // The last step's result goes straight to Out.
          if (r_cnt == CW'(1)) begin
            r_state  <= S_IDLE;
            r_out    <= w_fin_val;
            r_zero   <= (w_fin_val == '0);
            r_parity <= ^w_fin_val;
            r_odd    <= w_fin_val[0];
            r_carry  <= w_fin_c;
            r_done   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Out    = r_out;
  assign Busy   = (r_state == S_EXEC);
  assign Done   = r_done;
  assign Zero   = r_zero;
  assign Parity = r_parity;
  assign Odd    = r_odd;
  assign Carry  = r_carry;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard testbench for alu_seq (W=8, Ops=4)
module tb_alu_seq;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1, Start = 1'b0;
  logic [7:0] InputA = '0, InputB = '0;
  logic [3:0] OP = '0;
  logic [7:0] Out;
  logic       Busy, Done, Zero, Parity, Odd, Carry;

  alu_seq #(.W(8), .Ops(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InputA(InputA), .InputB(InputB),
    .OP(OP), .Out(Out), .Busy(Busy), .Done(Done), .Zero(Zero), .Parity(Parity),
    .Odd(Odd), .Carry(Carry)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] out;
    logic       z, p, o, c;
    int         when;
  } exp_t;

  exp_t   sb[$];
  exp_t   held;
  int     cyc = 0;
  int     busy_lo = 0, busy_hi = 0, free_at = 0;
  bit     accepted;
  bit     mon_en = 1'b0;
  int     checks = 0, failures = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic over the opcode table.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       output exp_t e, output int lat);
    int ai, bi, r, c;
    ai = a; bi = b; r = 0; c = 0; lat = 0;
    case (op)
      0: begin r = ai + bi; c = (r > 255); end
      1: begin r = ai - bi; c = (ai < bi); end
      2: r = ai & bi;
      3: r = ai | bi;
      4: r = ai ^ bi;
      5: if (bi < 8) begin
           r = ai << bi; c = (bi > 0) ? ((r >> 8) & 1) : 0; lat = bi;
         end
      6: if (bi < 8) begin
           r = ai >> bi; c = (bi > 0) ? ((ai >> (bi - 1)) & 1) : 0; lat = bi;
         end
      7: r = -ai;
      8: r = (ai >= bi);
      9: r = (ai == bi);
      10: r = (ai != bi);
`ifdef ALU_SEQ_MUL_EN
      11: begin r = ai * bi; c = ((r >> 8) != 0); lat = 8; end
`endif
      default: r = 0;
    endcase
    e.out = r[7:0];
    e.z = (e.out == 8'h00);
    e.p = ^e.out;
    e.o = e.out[0];
    e.c = c[0];
    e.when = 0;
  endtask

  task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic rst);
    exp_t e;
    int   lat;
    @(negedge Clk);
    Start = s; InputA = a; InputB = b; OP = op; Reset = rst;
    accepted = 1'b0;
    if (rst) begin
      sb.delete();
      held = '{out: 8'h00, z: 1'b0, p: 1'b0, o: 1'b0, c: 1'b0, when: 0};
      busy_hi = 0;
      free_at = cyc + 2;
    end else if (s && (cyc + 1 >= free_at)) begin
      model(a, b, op, e, lat);
      e.when = cyc + 1 + lat;
      sb.push_back(e);
      busy_lo = cyc + 1;
      busy_hi = cyc + 1 + lat;
      free_at = cyc + 2 + lat;
      accepted = 1'b1;
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, a, b, op, 1'b0);
      if (accepted) break;
    end
    if (!accepted) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
  endtask

  // Monitor: pops the scoreboard on Done, and every cycle checks Busy and
  // that Out/flags hold the last completed result.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (mon_en) begin
        check("busy", {31'd0, Busy}, {31'd0, (cyc >= busy_lo && cyc < busy_hi)});
        if (Done) begin
          if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("done_cycle", cyc, e.when);
            held = e;
          end
        end else if (sb.size() > 0 && sb[0].when <= cyc) begin
          e = sb.pop_front();
          check("missing_done", 32'd0, 32'd1);
          held = e;
        end
        check("out_flags", {20'd0, Out, Zero, Parity, Odd, Carry},
              {20'd0, held.out, held.z, held.p, held.o, held.c});
      end
    end
  end

  initial begin
    held = '{out: 8'h00, z: 1'b0, p: 1'b0, o: 1'b0, c: 1'b0, when: 0};
    // Reset with Start asserted: reset wins.
    drive(1'b1, 8'h12, 8'h34, 4'h0, 1'b1);
    drive(1'b1, 8'h12, 8'h34, 4'h0, 1'b1);
    mon_en = 1'b1;
    idle(2);

    issue(8'hF0, 8'h20, 4'd0);   // ADD -> 10, carry
    issue(8'h81, 8'h03, 4'd6);   // RSH 3 -> 10, carry 0
    issue(8'h81, 8'h01, 4'd5);   // LSH 1 -> 02, carry 1
    issue(8'h81, 8'h00, 4'd5);   // k=0
    issue(8'h81, 8'h09, 4'd6);   // out of range shift
    issue(8'h05, 8'h09, 4'd1);   // SUB borrow
    issue(8'h07, 8'h00, 4'd7);   // NEG
    issue(8'h0D, 8'h0B, 4'd11);  // MUL 13x11
    // Start every cycle with fresh operands while busy; only the accept-able ones count.
    for (int i = 0; i < 12; i++)
      drive(1'b1, 8'($urandom), 8'($urandom_range(0, 9)), 4'($urandom_range(0, 15)), 1'b0);
    idle(10);
    issue(8'h10, 8'h10, 4'd11);  // MUL 16x16
    issue(8'h55, 8'h55, 4'd9);   // EQ
    issue(8'h04, 8'h05, 4'd8);   // GEQ false
    issue(8'h0C, 8'h0F, 4'd15);  // undefined opcode
    idle(10);

    // Reset mid-operation: no Done afterwards.
    issue(8'hC8, 8'h03, 4'd11);
    idle(3);
    drive(1'b1, 8'h01, 8'h01, 4'd0, 1'b1);
    idle(12);
    issue(8'hFF, 8'h07, 4'd6);
    idle(2);
    drive(1'b0, 8'h00, 8'h00, 4'd0, 1'b1);
    idle(10);

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9)),
            4'($urandom_range(0, 15)), $urandom_range(0, 99) == 0);
    end
    idle(20);
    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
